// File: rtl/bsg_link_stream_checker_pkg.sv
// Shared types and helpers for the link stream checker: FSM states, LFSR constants, pattern builder.
package bsg_link_stream_checker_pkg;

  typedef enum logic {
    SYNC  = 1'b0,
    CHECK = 1'b1
  } state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1: feedback from bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  localparam int PAT_MAX_W = 512;

  // Returns {seq[h-1:0], ~seq[h-1:0]} right-aligned in a PAT_MAX_W vector; seq must be zero above h.
  function automatic logic [PAT_MAX_W-1:0] pattern(input logic [PAT_MAX_W/2-1:0] seq, input int h);
    logic [PAT_MAX_W-1:0] mask;
    logic [PAT_MAX_W-1:0] hi;
    logic [PAT_MAX_W-1:0] lo;
    mask = (PAT_MAX_W'(1) << h) - PAT_MAX_W'(1);
    hi   = PAT_MAX_W'(seq) << h;
    lo   = {{(PAT_MAX_W/2){1'b0}}, ~seq} & mask;
    return hi | lo;
  endfunction

endpackage

// File: rtl/bsg_link_stream_checker_lfsr.sv
// 16-bit Fibonacci LFSR used as a random accept throttle; advances each cycle en_i is high.
// Output is the current low bit; reset loads seed_p.
module bsg_link_stream_checker_lfsr
  import bsg_link_stream_checker_pkg::*;
#(
  parameter logic [15:0] seed_p = LFSR_SEED
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic en_i,
  output logic bit_o
);

  logic [15:0] lfsr_q, lfsr_d;
  logic        fb;

  always_comb begin
    fb     = ^(lfsr_q & LFSR_TAPS);
    lfsr_d = en_i ? {fb, lfsr_q[15:1]} : lfsr_q;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) lfsr_q <= seed_p;
    else            lfsr_q <= lfsr_d;
  end

  assign bit_o = lfsr_q[0];

endmodule

// File: rtl/bsg_link_stream_checker.sv
// Counter-pattern stream checker after the link downstream; yumi_o is combinational, err_o one cycle later.
// Backpressure: accepts only when en_i (and, with BSG_LINK_STREAM_CHECKER_THROTTLE_EN, a random LFSR bit).
module bsg_link_stream_checker
  import bsg_link_stream_checker_pkg::*;
#(
  parameter int width_p       = 64,
  parameter int lose_thresh_p = 4,
  parameter int cnt_width_p   = 32
) (
  input  logic                   core_clk_i,
  input  logic                   core_link_reset_n_i,
  input  logic                   en_i,
  input  logic                   clear_i,
  input  logic [width_p-1:0]     data_i,
  input  logic                   valid_i,
  output logic                   yumi_o,
  output logic                   locked_o,
  output logic                   err_o,
  output logic                   err_sticky_o,
  output logic [cnt_width_p-1:0] rx_cnt_o,
  output logic [cnt_width_p-1:0] err_cnt_o
);

  localparam int h_lp      = width_p / 2;
  localparam int miss_w_lp = $clog2(lose_thresh_p + 1);

  state_e                 state_q, state_d;
  logic [h_lp-1:0]        exp_q, exp_d;
  logic [miss_w_lp-1:0]   miss_q, miss_d, miss_inc;
  logic [cnt_width_p-1:0] rx_cnt_q, rx_cnt_d;
  logic [cnt_width_p-1:0] err_cnt_q, err_cnt_d;
  logic                   err_q, err_d;
  logic                   sticky_q, sticky_d;
  logic                   throttle_ok;
  logic                   sync_ok, match;
  logic [PAT_MAX_W/2-1:0] seq_ext;
  logic [PAT_MAX_W-1:0]   data_ext;

`ifdef BSG_LINK_STREAM_CHECKER_THROTTLE_EN
  bsg_link_stream_checker_lfsr #(.seed_p(LFSR_SEED)) lfsr_u (
    .clk_i    (core_clk_i),
    .reset_n_i(core_link_reset_n_i),
    .en_i     (1'b1),
    .bit_o    (throttle_ok)
  );
`else
  assign throttle_ok = 1'b1;
`endif

  // Reset gating keeps the source from seeing a consume that the reset branch would drop.
  assign yumi_o = valid_i & en_i & core_link_reset_n_i & throttle_ok;

  always_comb begin
    seq_ext               = '0;
    seq_ext[h_lp-1:0]     = exp_q;
    data_ext              = '0;
    data_ext[width_p-1:0] = data_i;
  end

  assign sync_ok  = (data_i[h_lp-1:0] == ~data_i[width_p-1:h_lp]);
  assign match    = (pattern(seq_ext, h_lp) == data_ext);
  assign miss_inc = miss_q + miss_w_lp'(1);

  always_comb begin
    state_d   = state_q;
    exp_d     = exp_q;
    miss_d    = miss_q;
    rx_cnt_d  = rx_cnt_q;
    err_cnt_d = err_cnt_q;
    err_d     = 1'b0;
    sticky_d  = sticky_q;
    if (clear_i) begin
      state_d   = SYNC;
      miss_d    = '0;
      rx_cnt_d  = '0;
      err_cnt_d = '0;
      sticky_d  = 1'b0;
    end else if (yumi_o) begin
      case (state_q)
        SYNC: begin
          if (sync_ok) begin
            exp_d   = data_i[width_p-1:h_lp] + h_lp'(1);
            miss_d  = '0;
            state_d = CHECK;
          end
        end
        CHECK: begin
          rx_cnt_d = (&rx_cnt_q) ? rx_cnt_q : rx_cnt_q + cnt_width_p'(1);
          // Expected sequence free-runs on mismatch so a single corrupted word costs one error.
          exp_d    = exp_q + h_lp'(1);
          if (match) begin
            miss_d = '0;
          end else begin
            err_cnt_d = (&err_cnt_q) ? err_cnt_q : err_cnt_q + cnt_width_p'(1);
            err_d     = 1'b1;
            sticky_d  = 1'b1;
            if (miss_inc == miss_w_lp'(lose_thresh_p)) begin
              state_d = SYNC;
              miss_d  = '0;
            end else begin
              miss_d = miss_inc;
            end
          end
        end
        default: state_d = SYNC;
      endcase
    end
  end

  always_ff @(posedge core_clk_i) begin
    if (!core_link_reset_n_i) begin
      state_q   <= SYNC;
      exp_q     <= '0;
      miss_q    <= '0;
      rx_cnt_q  <= '0;
      err_cnt_q <= '0;
      err_q     <= 1'b0;
      sticky_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      exp_q     <= exp_d;
      miss_q    <= miss_d;
      rx_cnt_q  <= rx_cnt_d;
      err_cnt_q <= err_cnt_d;
      err_q     <= err_d;
      sticky_q  <= sticky_d;
    end
  end

  assign locked_o     = (state_q == CHECK);
  assign err_o        = err_q;
  assign err_sticky_o = sticky_q;
  assign rx_cnt_o     = rx_cnt_q;
  assign err_cnt_o    = err_cnt_q;

endmodule

// File: tb/tb_bsg_link_stream_checker.sv
// Scoreboard bench for bsg_link_stream_checker: stimulus queues hand-computed post-consume state, monitor compares.
module tb_bsg_link_stream_checker;

  logic        clk;
  logic        reset_n;
  logic        en_i;
  logic        clear_i;
  logic [63:0] data_i;
  logic        valid_i;
  logic        yumi_o;
  logic        locked_o;
  logic        err_o;
  logic        err_sticky_o;
  logic [31:0] rx_cnt_o;
  logic [31:0] err_cnt_o;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic        lk;
    logic [31:0] rx;
    logic [31:0] ec;
    logic        st;
    logic        ep;
    logic [15:0] tag;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [15:0] tag_ctr = 16'd0;

`ifdef BSG_LINK_STREAM_CHECKER_THROTTLE_EN
  localparam int N_STREAM = 1000;
`else
  localparam int N_STREAM = 40;
`endif

  bsg_link_stream_checker #(
    .width_p      (64),
    .lose_thresh_p(4),
    .cnt_width_p  (32)
  ) dut (
    .core_clk_i         (clk),
    .core_link_reset_n_i(reset_n),
    .en_i               (en_i),
    .clear_i            (clear_i),
    .data_i             (data_i),
    .valid_i            (valid_i),
    .yumi_o             (yumi_o),
    .locked_o           (locked_o),
    .err_o              (err_o),
    .err_sticky_o       (err_sticky_o),
    .rx_cnt_o           (rx_cnt_o),
    .err_cnt_o          (err_cnt_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [63:0] pat(input logic [31:0] s);
    return {s, ~s};
  endfunction

  task automatic chk(input string nm, input int tag, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s (vec %0d): got %0h, expected %0h", nm, tag, act, expv);
    end
  endtask

  // Queue the state expected right after this word is consumed, then offer it until accepted.
  task automatic send(input logic [63:0] d, input logic clr, input logic lk,
                      input logic [31:0] rx, input logic [31:0] ec, input logic st, input logic ep);
    int   n;
    logic got;
    sb_q.push_back('{lk, rx, ec, st, ep, tag_ctr});
    tag_ctr++;
    @(negedge clk);
    data_i  = d;
    valid_i = 1'b1;
    clear_i = clr;
    n   = 0;
    got = 1'b0;
    while (!got && n < 200) begin
      @(posedge clk);
      got = yumi_o;
      n++;
    end
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: got no yumi in %0d cycles, expected a consume", n);
      void'(sb_q.pop_back());
    end
  endtask

  task automatic idle();
    @(negedge clk);
    valid_i = 1'b0;
    clear_i = 1'b0;
  endtask

  always @(posedge clk) begin
    if (valid_i && yumi_o) begin
      #1;
      if (sb_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_consume: got a consume, expected none");
      end else begin
        mon_e = sb_q.pop_front();
        chk("locked", int'(mon_e.tag), 32'(locked_o), 32'(mon_e.lk));
        chk("rx_cnt", int'(mon_e.tag), rx_cnt_o, mon_e.rx);
        chk("err_cnt", int'(mon_e.tag), err_cnt_o, mon_e.ec);
        chk("sticky", int'(mon_e.tag), 32'(err_sticky_o), 32'(mon_e.st));
        chk("err_pulse", int'(mon_e.tag), 32'(err_o), 32'(mon_e.ep));
      end
    end
  end

  always @(negedge clk) begin
    if (yumi_o && !valid_i) begin
      vectors++;
      miscompares++;
      $display("FAIL yumi_wo_valid: got yumi 1, expected 0");
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    en_i    = 1'b1;
    clear_i = 1'b0;
    valid_i = 1'b1;
    data_i  = pat(32'd3);
    repeat (3) @(negedge clk);
    chk("rst_yumi", 0, 32'(yumi_o), 32'd0);
    chk("rst_locked", 0, 32'(locked_o), 32'd0);
    chk("rst_err", 0, 32'(err_o), 32'd0);
    chk("rst_sticky", 0, 32'(err_sticky_o), 32'd0);
    chk("rst_rx", 0, rx_cnt_o, 32'd0);
    chk("rst_errcnt", 0, err_cnt_o, 32'd0);
    valid_i = 1'b0;
    reset_n = 1'b1;

    // Lock on seq 5; 6..9 counted.
    send(pat(32'd5), 1'b0, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0);
    send(pat(32'd6), 1'b0, 1'b1, 32'd1, 32'd0, 1'b0, 1'b0);
    send(pat(32'd7), 1'b0, 1'b1, 32'd2, 32'd0, 1'b0, 1'b0);
    send(pat(32'd8), 1'b0, 1'b1, 32'd3, 32'd0, 1'b0, 1'b0);
    send(pat(32'd9), 1'b0, 1'b1, 32'd4, 32'd0, 1'b0, 1'b0);
    // Stream skipped seq 10: both shifted words miss, then expected catches up at 12.
    send(pat(32'd11), 1'b0, 1'b1, 32'd5, 32'd1, 1'b1, 1'b1);
    send(pat(32'd12), 1'b0, 1'b1, 32'd6, 32'd2, 1'b1, 1'b1);
    send(pat(32'd12), 1'b0, 1'b1, 32'd7, 32'd2, 1'b1, 1'b0);
    // Clear concurrent with a consume wins.
    send(pat(32'd13), 1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    // Relock, then four garbage words drop lock.
    send(pat(32'd100), 1'b0, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0);
    send(pat(32'd101), 1'b0, 1'b1, 32'd1, 32'd0, 1'b0, 1'b0);
    send(64'hDEAD_BEEF_0000_0000, 1'b0, 1'b1, 32'd2, 32'd1, 1'b1, 1'b1);
    send(64'hDEAD_BEEF_0000_0000, 1'b0, 1'b1, 32'd3, 32'd2, 1'b1, 1'b1);
    send(64'hDEAD_BEEF_0000_0000, 1'b0, 1'b1, 32'd4, 32'd3, 1'b1, 1'b1);
    send(64'hDEAD_BEEF_0000_0000, 1'b0, 1'b0, 32'd5, 32'd4, 1'b1, 1'b1);
    send(64'hDEAD_BEEF_0000_0000, 1'b0, 1'b0, 32'd5, 32'd4, 1'b1, 1'b0);
    // Idle clear.
    @(negedge clk);
    valid_i = 1'b0;
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
    chk("clr_rx", 0, rx_cnt_o, 32'd0);
    chk("clr_errcnt", 0, err_cnt_o, 32'd0);
    chk("clr_sticky", 0, 32'(err_sticky_o), 32'd0);
    // Sequence wrap is a match.
    send(pat(32'hFFFF_FFFE), 1'b0, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0);
    send(pat(32'hFFFF_FFFF), 1'b0, 1'b1, 32'd1, 32'd0, 1'b0, 1'b0);
    send(pat(32'h0000_0000), 1'b0, 1'b1, 32'd2, 32'd0, 1'b0, 1'b0);
    // en_i low pauses the checker.
    @(negedge clk);
    en_i    = 1'b0;
    data_i  = pat(32'd1);
    valid_i = 1'b1;
    clear_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("en_low_yumi", i, 32'(yumi_o), 32'd0);
    end
    chk("en_low_rx", 0, rx_cnt_o, 32'd2);
    chk("en_low_locked", 0, 32'(locked_o), 32'd1);
    valid_i = 1'b0;
    en_i    = 1'b1;
    send(pat(32'd1), 1'b0, 1'b1, 32'd3, 32'd0, 1'b0, 1'b0);
    for (int s = 2; s < N_STREAM + 2; s++) begin
      send(pat(32'(s)), 1'b0, 1'b1, 32'(s + 2), 32'd0, 1'b0, 1'b0);
    end
    idle();
    repeat (3) @(negedge clk);
    chk("sb_drained", 0, 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
